// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: N x N weight-stationary signed matrix-vector engine with valid/ready streams.
// Ports: w_valid/w_ready/w_data load weight rows; a_valid/a_ready/a_data/a_last stream activations;
// out_valid/out_ready/out_data/out_last stream results; weights_ok, busy and done report status.
module systolic_matmul_engine #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [N*DW-1:0] w_data,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [N*DW-1:0] a_data,
    input  logic            a_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*AW-1:0] out_data,
    output logic            out_last,
    output logic            weights_ok,
    output logic            busy,
    output logic            done
);
    localparam int LAT = 2*N+1;
    localparam int CW  = $clog2(LAT+1)+1;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COMP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] row_q, row_d, w_row;
    logic          wok_q, wok_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LAT-1:0] vld_q, vld_d, lst_q, lst_d;
    logic          adv, a_acc, w_acc, o_hs;
    logic signed [DW-1:0] row_in [N];
    logic signed [DW-1:0] acts [N][N-1];
    logic signed [AW-1:0] psum [N][N];
    logic signed [AW-1:0] col_out [N];

    // The whole pipe advances unless a valid result is being held back by the consumer.
    assign out_valid  = vld_q[LAT-1];
    assign out_last   = lst_q[LAT-1];
    assign adv        = !(out_valid && !out_ready);
    assign o_hs       = out_valid && out_ready;
    assign a_ready    = (state_q == S_IDLE && wok_q) || (state_q == S_COMP && adv);
    // In IDLE a pending activation takes priority, so weights are only offered when it cannot go.
    assign w_ready    = !rst && (state_q == S_LOAD || (state_q == S_IDLE && !(a_valid && wok_q)));
    assign a_acc      = a_valid && a_ready;
    assign w_acc      = w_valid && w_ready;
    assign w_row      = (state_q == S_IDLE) ? '0 : row_q;
    assign weights_ok = wok_q;
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DRAIN && cnt_q == '0;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wok_d   = wok_q;
        if (state_q == S_IDLE) begin
            if (a_acc) state_d = a_last ? S_DRAIN : S_COMP;
            else if (w_acc) begin
                state_d = S_LOAD;
                row_d   = KW'(1);
                wok_d   = 1'b0;
            end
        end else if (state_q == S_LOAD) begin
            if (w_acc) begin
                row_d = row_q + KW'(1);
                if (row_q == KW'(N-1)) begin
                    row_d   = '0;
                    wok_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end else if (state_q == S_COMP) begin
            if (a_acc && a_last) state_d = S_DRAIN;
        end else if (cnt_q == '0) state_d = S_IDLE;
        cnt_d = cnt_q + CW'(a_acc) - CW'(o_hs);
        vld_d = adv ? {vld_q[LAT-2:0], a_acc} : vld_q;
        lst_d = adv ? {lst_q[LAT-2:0], a_acc && a_last} : lst_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            wok_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wok_q   <= wok_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
        end
    end

    // Input skew: row k sees its element k cycles after row 0; bubbles enter as zeros.
    for (genvar k = 0; k < N; k++) begin : g_skew
        logic signed [DW-1:0] sk_q [k+1];
        logic signed [DW-1:0] sk_d [k+1];
        always_comb begin
            sk_d[0] = a_acc ? a_data[k*DW +: DW] : '0;
            for (int i = 1; i <= k; i++) sk_d[i] = sk_q[i-1];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) for (int i = 0; i <= k; i++) sk_q[i] <= '0;
            else if (adv) sk_q <= sk_d;
        end
        assign row_in[k] = sk_q[k];
    end

    // PE(k,j): activation moves right, partial sum moves down, weight W[k][j] stays put.
    for (genvar k = 0; k < N; k++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0]   wt_q, wt_d, al;
            logic signed [AW-1:0]   ps_q, ps_d, pin;
            logic signed [2*DW-1:0] prod;
            if (j == 0) begin : g_l0
                assign al = row_in[k];
            end else begin : g_ln
                assign al = acts[k][j-1];
            end
            if (k == 0) begin : g_t0
                assign pin = '0;
            end else begin : g_tn
                assign pin = psum[k-1][j];
            end
            always_comb begin
                wt_d = (w_acc && w_row == KW'(k)) ? w_data[j*DW +: DW] : wt_q;
                prod = al * wt_q;
                ps_d = pin + {{(AW-2*DW){prod[2*DW-1]}}, prod};
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wt_q <= '0;
                    ps_q <= '0;
                end else begin
                    wt_q <= wt_d;
                    if (adv) ps_q <= ps_d;
                end
            end
            assign psum[k][j] = ps_q;
            if (j < N-1) begin : g_act
                logic signed [DW-1:0] act_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) act_q <= '0;
                    else if (adv) act_q <= al;
                end
                assign acts[k][j] = act_q;
            end
        end
    end

    // Output de-skew: column j finishes j cycles after column 0, so it is delayed N-1-j to realign.
    for (genvar j = 0; j < N; j++) begin : g_out
        localparam int D = N-1-j;
        logic signed [AW-1:0] out_q;
        if (D == 0) begin : g_nd
            assign col_out[j] = psum[N-1][j];
        end else begin : g_ds
            logic signed [AW-1:0] ds_q [D];
            logic signed [AW-1:0] ds_d [D];
            always_comb begin
                ds_d[0] = psum[N-1][j];
                for (int i = 1; i < D; i++) ds_d[i] = ds_q[i-1];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) for (int i = 0; i < D; i++) ds_q[i] <= '0;
                else if (adv) ds_q <= ds_d;
            end
            assign col_out[j] = ds_q[D-1];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) out_q <= '0;
            else if (adv) out_q <= col_out[j];
        end
        assign out_data[j*AW +: AW] = out_q;
    end
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// tb_systolic_matmul_engine: directed table-driven bench for systolic_matmul_engine.
module tb_systolic_matmul_engine;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 24;

    logic            clk = 1'b0, rst = 1'b1;
    logic            w_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0, out_ready = 1'b1;
    logic [N*DW-1:0] w_data = '0, a_data = '0;
    logic            w_ready, a_ready, out_valid, out_last, weights_ok, busy, done;
    logic [N*AW-1:0] out_data;

    systolic_matmul_engine #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .weights_ok(weights_ok), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] a;
        logic [N*AW-1:0] e;
        logic            l;
    } vec_t;

    vec_t tbl [18];
    int checks = 0, fails = 0, done_cnt = 0, cyc = 0;
    int acc_q [$];
    int oc_q [$];
    logic [N*AW-1:0] od_q [$];
    logic ol_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid && a_ready) acc_q.push_back(cyc);
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                ol_q.push_back(out_last);
                oc_q.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [N*DW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [N*AW-1:0] pe(input int e0, input int e1, input int e2, input int e3);
        return {24'(e3), 24'(e2), 24'(e1), 24'(e0)};
    endfunction

    function automatic logic [N*DW-1:0] id_row(input int k);
        logic [N*DW-1:0] r;
        r = '0;
        r[k*DW] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_weights_ok"}, weights_ok, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic send_w(input logic [N*DW-1:0] r);
        bit hs;
        int t;
        w_valid = 1'b1;
        w_data  = r;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = w_ready;
            step();
            t++;
        end
        if (!hs) chk("w_accept_timeout", 0, 1);
    endtask

    task automatic load_w(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                          input logic [N*DW-1:0] r2, input logic [N*DW-1:0] r3);
        send_w(r0);
        send_w(r1);
        send_w(r2);
        send_w(r3);
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [N*DW-1:0] v, input logic l);
        bit hs;
        int t;
        a_valid = 1'b1;
        a_data  = v;
        a_last  = l;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = a_ready;
            step();
            t++;
        end
        if (!hs) chk("a_accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit hs;
        int t;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 100) begin
            @(negedge clk);
            hs = done;
            t++;
        end
        if (!hs) chk("done_timeout", 0, 1);
        step();
    endtask

    task automatic clear_q();
        acc_q.delete();
        oc_q.delete();
        od_q.delete();
        ol_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_outs(input int lo, input int hi, input bit lat);
        int n;
        n = hi - lo + 1;
        chk($sformatf("out_count[%0d..%0d]", lo, hi), od_q.size(), n);
        for (int i = 0; i < n && i < od_q.size(); i++) begin
            chk($sformatf("out_data[%0d]", lo + i), od_q[i], tbl[lo + i].e);
            chk($sformatf("out_last[%0d]", lo + i), ol_q[i], tbl[lo + i].l);
            if (lat && i < acc_q.size()) chk($sformatf("latency[%0d]", lo + i), oc_q[i] - acc_q[i], 9);
        end
        chk($sformatf("done_pulses[%0d..%0d]", lo, hi), done_cnt, 1);
        clear_q();
    endtask

    initial begin
        bit hs;
        int t;
        int idx;
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        tbl[0]  = '{pk(1, 2, 3, 4), pe(1, 2, 3, 4), 1'b1};
        tbl[1]  = '{pk(127, -128, 0, 1), pe(127, -128, 0, 1), 1'b1};
        for (int i = 0; i < 4; i++)
            tbl[2+i] = '{pk(i+1, i+1, i+1, i+1), pe(10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1)), 1'(i == 3)};
        for (int i = 0; i < 8; i++)
            tbl[6+i] = '{pk(i+1, i+1, i+1, i+1), pe(10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1)), 1'(i == 7)};
        tbl[14] = '{pk(-128, -128, -128, -128), pe(65536, 65536, 65536, 65536), 1'b1};
        tbl[15] = '{pk(1, 0, 0, 0), pe(-128, -128, -128, -128), 1'b0};
        tbl[16] = '{pk(0, 1, 1, 0), pe(-256, -256, -256, -256), 1'b0};
        tbl[17] = '{pk(2, 2, 2, 2), pe(-1024, -1024, -1024, -1024), 1'b1};

        step();
        step();
        chk_rst("reset");
        rst = 1'b0;
        step();

        // Identity weights: plain and signed passthrough.
        load_w(id_row(0), id_row(1), id_row(2), id_row(3));
        chk("weights_ok_loaded", weights_ok, 1);
        send_a(tbl[0].a, tbl[0].l);
        a_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        wait_done();
        check_outs(0, 0, 1);
        send_a(tbl[1].a, tbl[1].l);
        a_valid = 1'b0;
        wait_done();
        check_outs(1, 1, 1);

        // W[k][j] = k+1, back-to-back batch.
        load_w(pk(1, 1, 1, 1), pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(4, 4, 4, 4));
        for (int i = 2; i < 6; i++) send_a(tbl[i].a, tbl[i].l);
        a_valid = 1'b0;
        wait_done();
        check_outs(2, 5, 1);

        // Backpressure mid-batch: first result taken, then consumer stalls for 5 cycles.
        for (int i = 6; i < 10; i++) send_a(tbl[i].a, tbl[i].l);
        a_valid = 1'b0;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 40) begin
            @(negedge clk);
            hs = out_valid;
            t++;
        end
        chk("stall_first_out", hs, 1);
        step();
        out_ready = 1'b0;
        a_valid   = 1'b1;
        a_data    = tbl[10].a;
        a_last    = tbl[10].l;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_a_ready", a_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, tbl[7].e);
        end
        chk("stall_no_accept", acc_q.size(), 4);
        step();
        out_ready = 1'b1;
        for (int i = 10; i < 14; i++) send_a(tbl[i].a, tbl[i].l);
        a_valid = 1'b0;
        wait_done();
        check_outs(6, 13, 0);

        // Most-negative operands, then bubbles between beats.
        load_w(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128),
               pk(-128, -128, -128, -128), pk(-128, -128, -128, -128));
        send_a(tbl[14].a, tbl[14].l);
        a_valid = 1'b0;
        wait_done();
        check_outs(14, 14, 1);
        idx = 15;
        for (int i = 0; i < 6; i++) begin
            if (pat[i] != 0) begin
                a_valid = 1'b1;
                a_data  = tbl[idx].a;
                a_last  = tbl[idx].l;
                idx++;
            end else a_valid = 1'b0;
            step();
        end
        a_valid = 1'b0;
        wait_done();
        check_outs(15, 17, 1);

        // Reset during weight load (row 2 presented).
        send_w(pk(1, 1, 1, 1));
        send_w(pk(1, 1, 1, 1));
        w_valid = 1'b1;
        w_data  = pk(1, 1, 1, 1);
        @(negedge clk);
        chk("busy_in_load", busy, 1);
        rst = 1'b1;
        #1;
        chk_rst("rst_load");
        w_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rst_load_weights_ok", weights_ok, 0);

        // Reset while stalled in COMPUTE.
        load_w(pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        out_ready = 1'b0;
        send_a(pk(1, 1, 1, 1), 1'b0);
        send_a(pk(2, 2, 2, 2), 1'b0);
        a_valid = 1'b0;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 40) begin
            @(negedge clk);
            hs = out_valid;
            t++;
        end
        chk("rst_stall_reached", hs, 1);
        step();
        rst = 1'b1;
        #1;
        chk_rst("rst_stall");
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        clear_q();
        a_valid = 1'b1;
        a_data  = pk(5, 5, 5, 5);
        a_last  = 1'b1;
        repeat (12) step();
        chk("post_rst_accepts", acc_q.size(), 0);
        chk("post_rst_outs", od_q.size(), 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_weights_ok", weights_ok, 0);
        chk("post_rst_a_ready", a_ready, 0);
        a_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
